// File: rtl/floor_call_scheduler.sv
// floor_call_scheduler: debounced floor-call latching with a SCAN up/down scheduler driving a registered target floor.
module floor_call_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [1:0] cur_floor,
  input  logic       arrived,
  output logic [1:0] target,
  output logic [3:0] pending,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t     r_state, w_nstate;
  logic [3:0] r_s1, r_s2, r_db, r_db_q, r_pending, w_pending;
  logic [7:0] r_cnt [4];
  logic [1:0] r_target, w_target, w_lo_above, w_hi_below;
  logic       r_busy, w_up, w_dn;
  logic [3:0] w_press, w_here, w_clr, w_drop, w_above, w_below;
  always_comb begin
    w_press    = r_db & ~r_db_q;
    w_here     = 4'd1 << cur_floor;
    w_clr      = {4{arrived}} & w_here;
    w_drop     = w_clr | ({4{r_state == IDLE}} & w_here);
    w_pending  = (r_pending | (w_press & ~w_drop)) & ~w_clr;
    w_below    = r_pending & (w_here - 4'd1);
    w_above    = r_pending & ~(w_here - 4'd1) & ~w_here;
    w_up       = |w_above;
    w_dn       = |w_below;
    w_lo_above = w_above[0] ? 2'd0 : w_above[1] ? 2'd1 : w_above[2] ? 2'd2 : 2'd3;
    w_hi_below = w_below[3] ? 2'd3 : w_below[2] ? 2'd2 : w_below[1] ? 2'd1 : 2'd0;
    w_nstate   = (r_state == DOWN) ? (w_dn ? DOWN : w_up ? UP : IDLE)
                                   : (w_up ? UP : w_dn ? DOWN : IDLE);
    w_target   = (w_nstate == UP) ? w_lo_above : (w_nstate == DOWN) ? w_hi_below : r_target;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_db      <= '0;
      r_db_q    <= '0;
      r_pending <= '0;
      r_state   <= IDLE;
      r_target  <= '0;
      r_busy    <= 1'b0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s1      <= btn;
      r_s2      <= r_s1;
      r_db_q    <= r_db;
      r_pending <= w_pending;
      r_state   <= w_nstate;
      r_busy    <= w_nstate != IDLE;
      // only rewrite target on change so the downstream detector never sees a false edge
      if (w_target != r_target) r_target <= w_target;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == 8'(DEBOUNCE_CYCLES)) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 8'd1;
      end
    end
  end
  assign target  = r_target;
  assign pending = r_pending;
  assign busy    = r_busy;
endmodule

// File: tb/tb_floor_call_scheduler.sv
// tb_floor_call_scheduler: directed scenarios checked every cycle against a behavioural SCAN model.
module tb_floor_call_scheduler;
  localparam int D = 4;
  logic       clk = 1'b0, rst = 1'b1, arrived = 1'b0;
  logic [3:0] btn = '0;
  logic [1:0] cur_floor = '0;
  logic [1:0] target;
  logic [3:0] pending;
  logic       busy;
  int checks = 0, failures = 0;

  floor_call_scheduler #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn(btn), .cur_floor(cur_floor), .arrived(arrived),
    .target(target), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model: raw button log since reset, debounced level, pending set, direction (0 idle, 1 up, -1 down)
  logic [3:0] lg [256];
  int         n, m_dir, old_dir, up, dn, idx;
  logic [3:0] m_db, m_ev, m_pend;
  logic [1:0] m_tgt;
  logic       flip;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_db = '0; m_ev = '0; m_pend = '0; m_tgt = '0; m_dir = 0;
    end else begin
      up = -1;
      dn = -1;
      for (int f = 3; f > int'(cur_floor); f--) if (m_pend[f]) up = f;
      for (int f = 0; f < int'(cur_floor); f++) if (m_pend[f]) dn = f;
      old_dir = m_dir;
      if (m_dir == -1) begin
        if (dn >= 0) begin m_dir = -1; m_tgt = dn[1:0]; end
        else if (up >= 0) begin m_dir = 1; m_tgt = up[1:0]; end
        else m_dir = 0;
      end else begin
        if (up >= 0) begin m_dir = 1; m_tgt = up[1:0]; end
        else if (dn >= 0) begin m_dir = -1; m_tgt = dn[1:0]; end
        else m_dir = 0;
      end
      for (int f = 0; f < 4; f++) begin
        if (arrived && int'(cur_floor) == f) m_pend[f] = 1'b0;
        else if (m_ev[f] && !(old_dir == 0 && int'(cur_floor) == f)) m_pend[f] = 1'b1;
      end
      // a level is accepted once D+1 consecutive synchronised samples disagree with it
      lg[n % 256] = btn;
      n++;
      for (int f = 0; f < 4; f++) begin
        flip = 1'b1;
        for (int j = 0; j <= D; j++) begin
          idx = n - 3 - j;
          if (idx < 0) flip = 1'b0;
          else if (lg[idx % 256][f] == m_db[f]) flip = 1'b0;
        end
        m_ev[f] = flip && !m_db[f];
        if (flip) m_db[f] = ~m_db[f];
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_target", int'(target), int'(m_tgt));
    chk("cyc_pending", int'(pending), int'(m_pend));
    chk("cyc_busy", int'(busy), int'(m_dir != 0));
  end

  initial begin
    rst = 1'b1;
    btn = 4'($urandom);
    hold(1);
    btn = 4'($urandom);
    hold(1);
    rst = 1'b0;
    btn = '0;
    hold(5);
    chk("rst_target", int'(target), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_busy", int'(busy), 0);

    for (int r = 0; r < 5; r++) begin
      btn = 4'b0100; hold(3);
      btn = 4'b0000; hold(2);
    end
    chk("bounce_pending", int'(pending), 0);
    btn = 4'b0100;
    hold(7);
    chk("latency_early", int'(pending), 0);
    hold(1);
    chk("latency_pending", int'(pending), 4);
    hold(1);
    chk("latency_target", int'(target), 2);
    chk("latency_busy", int'(busy), 1);
    btn = '0; hold(10);
    cur_floor = 2; arrived = 1'b1; hold(1); arrived = 1'b0;
    chk("arr2_pending", int'(pending), 0);
    hold(1);
    chk("arr2_busy", int'(busy), 0);
    chk("arr2_target", int'(target), 2);

    cur_floor = 0; hold(2);
    btn = 4'b1000; hold(8);
    chk("single_pending", int'(pending), 8);
    hold(1);
    chk("single_target", int'(target), 3);
    chk("single_busy", int'(busy), 1);
    btn = '0; hold(10);
    cur_floor = 3; arrived = 1'b1; hold(1); arrived = 1'b0;
    chk("single_clr", int'(pending), 0);
    hold(1);
    chk("single_idle", int'(busy), 0);
    chk("single_hold", int'(target), 3);

    cur_floor = 0; hold(2);
    btn = 4'b0100; hold(9);
    chk("scan_t2", int'(target), 2);
    btn = '0; hold(10);
    cur_floor = 1;
    btn = 4'b1001; hold(8);
    chk("scan_pend", int'(pending), 13);
    hold(1);
    chk("scan_first", int'(target), 2);
    chk("scan_busy", int'(busy), 1);
    btn = '0; hold(10);
    cur_floor = 2; arrived = 1'b1; hold(1); arrived = 1'b0;
    chk("scan_p2", int'(pending), 9);
    hold(1);
    chk("scan_t3", int'(target), 3);
    cur_floor = 3; arrived = 1'b1; hold(1); arrived = 1'b0;
    chk("scan_p3", int'(pending), 1);
    hold(1);
    chk("scan_t0", int'(target), 0);
    chk("scan_down", int'(busy), 1);
    cur_floor = 0; arrived = 1'b1; hold(1); arrived = 1'b0;
    chk("scan_p0", int'(pending), 0);
    hold(1);
    chk("scan_idle", int'(busy), 0);
    chk("scan_hold", int'(target), 0);

    btn = 4'b1000; hold(9);
    chk("coll_t3", int'(target), 3);
    btn = '0; hold(10);
    cur_floor = 1;
    btn = 4'b0010; hold(7);
    arrived = 1'b1; hold(1); arrived = 1'b0;
    chk("coll_arrive", int'(pending), 8);
    btn = '0; hold(10);
    chk("coll_later", int'(pending), 8);
    cur_floor = 3; arrived = 1'b1; hold(1); arrived = 1'b0;
    hold(1);
    cur_floor = 1; hold(2);
    btn = 4'b0010; hold(10);
    chk("coll_idle", int'(pending), 0);
    chk("coll_idle_busy", int'(busy), 0);
    btn = '0; hold(10);

    cur_floor = 0;
    btn = 4'b1000; hold(9);
    btn = '0; hold(10);
    cur_floor = 2;
    btn = 4'b0010; hold(9);
    chk("mid_pending", int'(pending), 10);
    chk("mid_target", int'(target), 3);
    chk("mid_busy", int'(busy), 1);
    btn = 4'b0001; hold(3);
    rst = 1'b1; btn = '0; hold(1); rst = 1'b0;
    chk("mid_rst_target", int'(target), 0);
    chk("mid_rst_pending", int'(pending), 0);
    chk("mid_rst_busy", int'(busy), 0);
    hold(12);
    chk("mid_no_latch", int'(pending), 0);
    chk("mid_no_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/floor_call_scheduler.md
# floor_call_scheduler

Upstream stage of the elevator floor-change detector. Synchronises and debounces the four raw floor call buttons, latches pending requests, and runs a SCAN (up/down direction) scheduler. It produces the registered 2-bit `target` floor code. The downstream change detector consumes `target` and pulses whenever a new destination is issued.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a synchronised button level is accepted; range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn`  in  4  raw asynchronous call buttons; bit i = floor i; 1 = pressed.
- `cur_floor`  in  2  floor the car is at or last passed.
- `arrived`  in  1  one-cycle pulse: car stopped at `cur_floor`.
- `target`  out  2  registered destination floor.
- `pending`  out  4  registered latched requests, bit i = floor i.
- `busy`  out  1  registered; 1 when state is not IDLE.

## Operation

- **Synchroniser:** two flops per button.
- **Debounce:**
  - Each button has an 8-bit counter and a debounced level `db[i]`.
  - While the synced value equals `db[i]`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, `db[i]` takes the synced value and the counter clears.
- **Press event:** the cycle where `db[i]` rises 0 to 1. A release generates no event.
- **Request latch, per bit:**
  - Clear when `arrived` and `cur_floor==i`.
  - Set on a press event for i.
  - A press event is dropped if (`arrived` and `cur_floor==i`) or (state IDLE and `cur_floor==i`).
  - Clear wins over set.
- **Scheduler states:** IDLE, UP, DOWN. Next-state and `target` are computed from the already-updated `pending` value (call it P) and `cur_floor`.
  - IDLE:
    - If P has a bit above `cur_floor`, go to UP with `target` = lowest set bit above.
    - Else if P has a bit below, go to DOWN with `target` = highest set bit below.
    - Else stay in IDLE.
  - UP:
    - If a bit is above `cur_floor`, `target` = lowest such bit.
    - Else if a bit is below, go to DOWN with `target` = highest such bit.
    - Else go to IDLE.
  - DOWN: mirror of UP. Prefer the highest bit below; else go to UP with `target` = lowest bit above; else go to IDLE.
- In IDLE `target` holds its last value; it never follows `cur_floor`.
- Requests at `cur_floor` while moving remain pending until an `arrived` pulse with that `cur_floor`.
- `target` is written only when its new value differs, so the downstream detector sees no spurious pulses.

## Timing

- **Reset values:**
  - `target`=0, `pending`=0000, `busy`=0, state IDLE.
  - Synchroniser flops 0, `db`=0, counters 0.
  - Reset applies on any cycle, mid-debounce or mid-travel included. All requests are discarded.
- **Press latency:** `btn[i]` goes high and stays clean, first sampled at edge 0.
  - `pending[i]`=1 after edge DEBOUNCE_CYCLES+3.
  - `target`, state and `busy` update one edge later, at DEBOUNCE_CYCLES+4.
- **Arrival:** an `arrived` pulse at edge k clears `pending[cur_floor]` at edge k. `target`, state and `busy` reflect the new pending set at edge k+1.
- Glitches shorter than DEBOUNCE_CYCLES cycles, after synchronisation, never produce an event.
- Simultaneous press events on several floors in one cycle are all latched in that cycle.
- `arrived` with no matching pending bit changes nothing except via normal re-evaluation.

## Test plan

1. **Reset:** assert `rst` for 2 cycles with random `btn`. Then `target`=0, `pending`=0, `busy`=0, and they stay so while `btn`=0.
2. **Bounce rejection** (`DEBOUNCE_CYCLES`=4): toggle `btn[2]` high for 3 cycles, low for 2, repeated 5 times. `pending` stays 0000. Then hold it high. `pending`=0100 exactly 7 edges after the first held-high sample.
3. **Single call:** `cur_floor`=0, press floor 3.
   - `pending`=1000, then `target`=3 and `busy`=1 one cycle later.
   - Set `cur_floor`=3 and pulse `arrived`: `pending`=0000, next cycle `busy`=0, `target` holds 3.
4. **SCAN order:** car in UP, `cur_floor`=1, pending floors 3, 0 and 2.
   - `target`=2, then after `arrived` at 2, `target`=3.
   - After `arrived` at 3, state becomes DOWN with `target`=0. After `arrived` at 0, state becomes IDLE.
5. **Same-floor collision:** press event for floor 1 in the same cycle as `arrived` with `cur_floor`=1. `pending[1]` stays 0. A press at `cur_floor` while IDLE is also dropped.
6. **Reset mid-travel:** state UP with `pending`=1010, `target`=3, and a button mid-debounce. Assert `rst` for 1 cycle. All outputs return to reset values, and the mid-debounce press never latches.
